// File: rtl/fp_multiply_pipe.sv
`timescale 1ns/1ps
// fp_multiply_pipe: parametrised, fully pipelined floating-point multiplier.
// Flow: unpack -> significand multiply -> normalise/round -> pack/special-case.
// Rounding is round-to-nearest-even. Subnormal inputs are treated as zero.
// A tag travels with every operation. The whole pipe freezes while a result
// waits on out_ready_i. Define FP_MUL_FLAGS_EN to add the flags_o port and its
// exception pipeline ({invalid, overflow, underflow, inexact}).
module fp_multiply_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [EXP_W+MAN_W:0] a_i,
    input  logic [EXP_W+MAN_W:0] b_i,
    input  logic [TAG_W-1:0]     tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_W+MAN_W:0] product_o,
    output logic [TAG_W-1:0]     tag_o
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]           flags_o
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS    = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'(2 ** EXP_W - 1);

    // Per-operation side information that rides along with the data.
    typedef struct packed {
        logic             sign;
        logic             invalid;
        logic             is_inf;
        logic             is_zero;
        logic [TAG_W-1:0] tag;
    } meta_t;

    // Stage 1 combinational unpack
    logic [EXP_W-1:0]        w_a_exp, w_b_exp;
    logic [MAN_W-1:0]        w_a_man, w_b_man;
    logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic signed [XW-1:0]    w_exp_sum;
    meta_t                   w_s1_meta;

    assign w_a_exp  = a_i[W-2:MAN_W];
    assign w_b_exp  = b_i[W-2:MAN_W];
    assign w_a_man  = a_i[MAN_W-1:0];
    assign w_b_man  = b_i[MAN_W-1:0];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_man == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_man == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_man != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_man != '0);
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;

    assign w_s1_meta.sign    = a_i[W-1] ^ b_i[W-1];
    assign w_s1_meta.invalid = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    assign w_s1_meta.is_inf  = w_a_inf | w_b_inf;
    assign w_s1_meta.is_zero = w_a_zero | w_b_zero;
    assign w_s1_meta.tag     = tag_i;

    // Pipeline registers
    logic                 r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
    logic [MAN_W:0]       r_s1_ma, r_s1_mb;
    logic signed [XW-1:0] r_s1_exp, r_s2_exp, r_s3_exp;
    meta_t                r_s1_meta, r_s2_meta, r_s3_meta;
    logic [PW-1:0]        r_s2_prod;
    logic [MAN_W-1:0]     r_s3_man;
    logic [W-1:0]         r_product;
    logic [TAG_W-1:0]     r_tag;

    // Stall freezes every stage, bubbles included.
    logic w_stall, w_adv;
    assign w_stall    = r_out_valid & ~out_ready_i;
    assign w_adv      = ~w_stall;
    assign in_ready_o = w_adv;

    // Stage 3 combinational normalise and round
    logic [MAN_W-1:0]     w_man;
    logic                 w_guard, w_sticky, w_round_up;
    logic [MAN_W:0]       w_man_rnd;
    logic signed [XW-1:0] w_exp_norm, w_exp_fin;

    // Select the mantissa window from the product and round it to nearest-even.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_man      = r_s2_prod[PW-3 -: MAN_W];
        w_guard    = r_s2_prod[MAN_W-1];
        w_sticky   = |r_s2_prod[MAN_W-2:0];
        w_exp_norm = r_s2_exp;
        if (r_s2_prod[PW-1]) begin
            w_man      = r_s2_prod[PW-2 -: MAN_W];
            w_guard    = r_s2_prod[MAN_W];
            w_sticky   = |r_s2_prod[MAN_W-1:0];
            w_exp_norm = r_s2_exp + XW'(1);
        end
        w_round_up = w_guard & (w_sticky | w_man[0]);
        w_man_rnd  = {1'b0, w_man} + {{MAN_W{1'b0}}, w_round_up};
        // A carry out of rounding leaves the low bits at zero; only the exponent moves.
        w_exp_fin  = w_man_rnd[MAN_W] ? w_exp_norm + XW'(1) : w_exp_norm;
    end

    // Output stage combinational pack with special results in priority order
    logic [W-1:0] w_pack;
`ifdef FP_MUL_FLAGS_EN
    logic       r_s3_inexact;
    logic [3:0] r_flags;
    logic [3:0] w_pack_flags;
`endif

    // Choose between the rounded number and a special encoding.
    always_comb begin
        w_pack = {r_s3_meta.sign, r_s3_exp[EXP_W-1:0], r_s3_man};
`ifdef FP_MUL_FLAGS_EN
        w_pack_flags = {3'b000, r_s3_inexact};
`endif
        if (r_s3_meta.invalid) begin
            w_pack = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_pack_flags = 4'b1000;
`endif
        end else if (r_s3_meta.is_inf) begin
            w_pack = {r_s3_meta.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_pack_flags = 4'b0000;
`endif
        end else if (r_s3_meta.is_zero) begin
            w_pack = {r_s3_meta.sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_pack_flags = 4'b0000;
`endif
        end else if (!r_s3_exp[XW-1] && (r_s3_exp >= EXP_MAX)) begin
            w_pack = {r_s3_meta.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_pack_flags = 4'b0101;
`endif
        end else if (r_s3_exp[XW-1] || (r_s3_exp == '0)) begin
            w_pack = {r_s3_meta.sign, {(W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            w_pack_flags = 4'b0011;
`endif
        end
    end

    // Stage valid bits: the only pipeline state that needs clearing on reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: non-blocking assignments let each stage take its predecessor's pre-edge value.
        if (!reset_ni) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid_i;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
        end
    end

    // Datapath registers: unpack, multiply and round results move with the valids.
    always_ff @(posedge clk_i) begin
        // NOTE: no reset here; the valid bits decide whether these contents mean anything.
        if (w_adv) begin
            r_s1_ma   <= {1'b1, w_a_man};
            r_s1_mb   <= {1'b1, w_b_man};
            r_s1_exp  <= w_exp_sum;
            r_s1_meta <= w_s1_meta;
            r_s2_prod <= PW'(r_s1_ma) * PW'(r_s1_mb);
            r_s2_exp  <= r_s1_exp;
            r_s2_meta <= r_s1_meta;
            r_s3_man  <= w_man_rnd[MAN_W-1:0];
            r_s3_exp  <= w_exp_fin;
            r_s3_meta <= r_s2_meta;
        end
    end

    // Registered outputs are cleared on reset and held during a stall.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_tag       <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s3_valid;
            r_product   <= w_pack;
            r_tag       <= r_s3_meta.tag;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    // Exception bits follow the data so that they line up with product_o.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_flags <= 4'b0000;
        end else if (w_adv) begin
            r_flags <= w_pack_flags;
        end
    end

    // Inexact is captured beside the rounded mantissa.
    always_ff @(posedge clk_i) begin
        if (w_adv) begin
            r_s3_inexact <= w_guard | w_sticky;
        end
    end

    assign flags_o = r_flags;
`endif

    assign out_valid_o = r_out_valid;
    assign product_o   = r_product;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_fp_multiply_pipe.sv
`timescale 1ns/1ps
// Testbench for fp_multiply_pipe: scoreboard-checked directed and random
// traffic on a binary32 instance plus directed checks on a half-precision one.
module tb_fp_multiply_pipe;

    typedef struct packed {
        logic [31:0] prod;
        logic [3:0]  tag;
        logic [3:0]  flags;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a_in, b_in, product;
    logic [3:0]  tag_in, tag_out;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_product;
    logic [3:0]  h_tag_in, h_tag_out;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]  flags_out, h_flags;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    exp_t sb_q[$];
    bit   done;

    always #5 clk = ~clk;

    fp_multiply_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk_i(clk), .reset_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a_in), .b_i(b_in), .tag_i(tag_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .product_o(product), .tag_o(tag_out)
`ifdef FP_MUL_FLAGS_EN
        , .flags_o(flags_out)
`endif
    );

    fp_multiply_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_half (
        .clk_i(clk), .reset_ni(rst_n),
        .in_valid_i(h_in_valid), .in_ready_o(h_in_ready),
        .a_i(h_a), .b_i(h_b), .tag_i(h_tag_in),
        .out_valid_o(h_out_valid), .out_ready_i(h_out_ready),
        .product_o(h_product), .tag_o(h_tag_out)
`ifdef FP_MUL_FLAGS_EN
        , .flags_o(h_flags)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Reference: exact integer product, then nearest-even rounding by remainder.
    function automatic exp_t model(input int ew, input int mw, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        longint emax, bias, mmask, ea, eb, fa, fb, p, q, rem, half, e, sbit, qnan;
        int     k, sh;
        logic   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        exp_t   r;
        emax  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        mmask = (longint'(1) << mw) - 1;
        ea = (longint'(a) >> mw) & emax;
        eb = (longint'(b) >> mw) & emax;
        fa = longint'(a) & mmask;
        fb = longint'(b) & mmask;
        nan_a = (ea == emax) && (fa != 0);
        nan_b = (eb == emax) && (fb != 0);
        inf_a = (ea == emax) && (fa == 0);
        inf_b = (eb == emax) && (fb == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        sbit = longint'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
        qnan = (emax << mw) | (longint'(1) << (mw - 1));
        r.tag = tag;
        r.flags = 4'b0000;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            r.prod = 32'(qnan);
            r.flags = 4'b1000;
        end else if (inf_a || inf_b) begin
            r.prod = 32'(sbit | (emax << mw));
        end else if (zero_a || zero_b) begin
            r.prod = 32'(sbit);
        end else begin
            p = ((longint'(1) << mw) | fa) * ((longint'(1) << mw) | fb);
            k = 0;
            while ((p >> k) != 0) k++;
            sh   = k - (mw + 1);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            e = ea + eb - bias + longint'(k - (2 * mw + 1));
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                e++;
            end
            if (e >= emax) begin
                r.prod = 32'(sbit | (emax << mw));
                r.flags = 4'b0101;
            end else if (e <= 0) begin
                r.prod = 32'(sbit);
                r.flags = 4'b0011;
            end else begin
                r.prod = 32'(sbit | (e << mw) | (q & mmask));
                r.flags = {3'b000, rem != 0};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel;
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        sel = $urandom_range(0, 15);
        s   = 1'($urandom_range(0, 1));
        m   = 23'($urandom);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) m = '0;
        end else if (sel < 9) e = 8'($urandom_range(100, 154));
        else e = 8'($urandom_range(1, 254));
        if ($urandom_range(0, 3) == 0) m[11:0] = '0;
        return {s, e, m};
    endfunction

    // Present one operation until accepted; expectation is queued on acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] ep, input logic [3:0] ef);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        tag_in = tag;
        while (!acc) begin
            #4;
            acc = in_ready;
            if (acc) sb_q.push_back('{prod: ep, tag: tag, flags: ef});
            @(posedge clk);
            if (!acc) begin
                tries++;
                if (tries > 100) begin
                    fail("issue_timeout", "operand never accepted");
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        e = model(8, 23, a, b, tag);
        issue(a, b, tag, e.prod, e.flags);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic half_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                           input logic [15:0] ep);
        int c;
        c = 0;
        @(negedge clk);
        h_in_valid = 1'b1;
        h_a = a;
        h_b = b;
        h_tag_in = tag;
        @(negedge clk);
        h_in_valid = 1'b0;
        #1;
        while (!h_out_valid && c < 10) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("half_latency", c, 3);
        check("half_product", h_product, ep);
        check("half_tag", h_tag_out, tag);
`ifdef FP_MUL_FLAGS_EN
        check("half_flags", h_flags, 4'b0000);
`endif
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall holding.
    initial begin
        logic        prev_stall;
        logic [31:0] held_prod;
        logic [3:0]  held_tag;
        exp_t        e;
        prev_stall = 1'b0;
        held_prod = '0;
        held_tag = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {out_valid, tag_out, product}, {1'b1, held_tag, held_prod});
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb_q.size() == 0) begin
                        fail("unexpected_output", $sformatf("product %h tag %h with empty scoreboard", product, tag_out));
                    end else begin
                        e = sb_q.pop_front();
                        check("product", product, e.prod);
                        check("tag", tag_out, e.tag);
`ifdef FP_MUL_FLAGS_EN
                        check("flags", flags_out, e.flags);
`endif
                    end
                end
                prev_stall = out_valid && !out_ready;
                held_prod = product;
                held_tag = tag_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    vec_t dir_v[8] = '{
        '{32'hC0400000, 32'h40E00000, 32'hC1A80000, 4'b0000},
        '{32'h00000000, 32'h3F800000, 32'h00000000, 4'b0000},
        '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000},
        '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
        '{32'h3F7FFFFF, 32'h3F7FFFFF, 32'h3F7FFFFE, 4'b0001},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
        '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101},
        '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011}
    };

    initial begin
        int n0, w;
        in_valid = 1'b0; a_in = '0; b_in = '0; tag_in = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_tag_in = '0; h_out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 0);
        check("rst_tag", tag_out, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_half_valid", h_out_valid, 0);
`ifdef FP_MUL_FLAGS_EN
        check("rst_flags", flags_out, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2.5 x 4 with exact latency
        issue(32'h40200000, 32'h40800000, 4'd3, 32'h41200000, 4'b0000);
        idle();
        #1 check("lat_edge0", out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge1", out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge2", out_valid, 0);
        @(negedge clk);
        #1 check("lat_edge3", out_valid, 1);
        drain();

        // Directed values, rounding ties and specials, back to back
        for (int i = 0; i < 8; i++)
            issue(dir_v[i].a, dir_v[i].b, 4'(i + 4), dir_v[i].p, dir_v[i].f);
        idle();
        drain();

        // Half-precision instance
        half_op(16'h4100, 16'h4400, 4'd3, 16'h4900);
        half_op(16'hC200, 16'h4700, 4'd9, 16'hCD40);

        // Backpressure: six ops, output held off for five cycles after the first result
        out_ready = 1'b1;
        n0 = n_out;
        fork
            begin
                for (int t = 0; t < 6; t++)
                    issue_model({2'b00, 6'($urandom_range(28, 34)), 24'($urandom)},
                                {2'b01, 6'($urandom_range(0, 4)), 24'($urandom)}, 4'(t));
                idle();
            end
            begin
                w = 0;
                @(negedge clk);
                #1;
                while (!out_valid && w < 50) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                if (w >= 50) fail("bp_first_output", "no output appeared");
                @(negedge clk);
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    #1 check("bp_in_ready_low", in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_output_count", n_out - n0, 6);

        // Reset with operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) issue_model(rand_fp(), rand_fp(), 4'(i + 10));
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_product", product, 0);
        check("rst_mid_tag", tag_out, 0);
        check("rst_mid_in_ready", in_ready, 1);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n0 = n_out;
        repeat (10) @(negedge clk);
        check("rst_no_stale", n_out - n0, 0);

        // Random traffic with random gaps and random backpressure
        done = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    issue_model(rand_fp(), rand_fp(), 4'($urandom));
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_output_count", n_out - n0, 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_multiply_pipe.md
# fp_multiply_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready handshake, round-to-nearest-even, special-value handling and a pass-through tag. It is the general multiplier for the neural-network datapath. It is configurable in exponent and mantissa width, accepts one operand pair per cycle, and stalls cleanly under downstream backpressure. Default parameters give binary32.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa field width (≥2)
- TAG_W, 4, width of user tag carried alongside each operation (≥1)
- clk_i  in  1  clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  block can accept operands this cycle
- a_i, b_i  in  1+EXP_W+MAN_W  operands {sign, exp, man}
- tag_i  in  TAG_W  user tag
- out_valid_o  out  1  product valid
- out_ready_i  in  1  consumer accepts product
- product_o  out  1+EXP_W+MAN_W  result
- tag_o  out  TAG_W  tag of the operation on product_o
- flags_o  out  4  {invalid, overflow, underflow, inexact}; present only with FP_MUL_FLAGS_EN

## Operation
- BIAS = 2^(EXP_W-1)-1. Exp all-ones with man=0 is ±inf. Exp all-ones with man≠0 is NaN. Exp=0 is zero; subnormal inputs are flushed to zero.
- Stage 1 (unpack):
  - sign = sa^sb.
  - Classify zero/inf/NaN.
  - Significands get the hidden 1 prepended, giving MAN_W+1 bits.
  - Exponent sum ea+eb-BIAS is computed signed in EXP_W+2 bits.
- Stage 2 (multiply): full (2·MAN_W+2)-bit significand product is registered.
- Stage 3 (normalise/round/pack):
  - If the product MSB is set: shift right 1 and exp+1.
  - Take MAN_W bits. Guard = next bit. Sticky = OR of the rest.
  - Round nearest-even: increment if guard && (sticky || lsb).
  - A rounding carry-out renormalises: mantissa=0, exp+1.
- Special results, in priority order:
  - NaN in, or inf×0: canonical qNaN {0, all-ones, 1, 0…}, invalid=1.
  - inf×finite-nonzero or inf×inf: ±inf.
  - Either operand zero: ±0.
  - Final biased exp ≥ all-ones: ±inf, overflow=1, inexact=1.
  - Final biased exp ≤ 0: ±0 flush, underflow=1, inexact=1.
- inexact = guard|sticky for normal results.
- Tags and class bits travel with their operation through all stages.
- Handshake:
  - Input transfer occurs when in_valid_i && in_ready_o.
  - Output transfer occurs when out_valid_o && out_ready_i.
  - Stall = out_valid_o && !out_ready_i. During a stall every stage holds, including bubbles.
  - in_ready_o = !stall (combinational from out_ready_i and out_valid_o).
- Order is preserved. No operation is dropped or duplicated.

## Timing
- Latency: 3 cycles. An operand accepted at edge N produces out_valid_o after edge N+3, absent stalls. Each stall cycle adds one cycle.
- Throughput: 1 operation/cycle when out_ready_i=1.
- Reset (reset_ni=0, any time, including mid-pipeline):
  - All stage valids clear immediately.
  - out_valid_o=0, product_o=0, tag_o=0, flags_o=0.
  - in_ready_o=1 after reset.
  - In-flight operations are discarded.
- Outputs are registered. product_o, tag_o and flags_o are stable while out_valid_o && !out_ready_i.
- Bubbles advance whenever there is no stall. in_valid_i=0 produces out_valid_o=0 three cycles later.
- Simultaneous output transfer and input acceptance in the same cycle is legal and is the steady state.

## Configuration
- FP_MUL_FLAGS_EN defined:
  - flags_o port exists.
  - Exception bits are pipelined alongside the data, aligned with product_o.
- FP_MUL_FLAGS_EN undefined:
  - flags_o port and its registers are absent.
  - product_o, tag_o and timing are bit-identical to the defined build.

## Test plan
- 0x40200000×0x40800000 (2.5×4), tag 3 → 0x41200000, tag_o=3, out_valid_o exactly 3 cycles after accept.
- 0xC0400000×0x40E00000 (-3×7) → 0xC1A80000. 0x00000000×0x3F800000 → 0x00000000. 0x80000000×0x3F800000 → 0x80000000.
- RNE tie: 0x3F800001×0x3FC00000 → 0x3FC00002, inexact=1. Also 0x3F7FFFFF×0x3F7FFFFF → 0x3F7FFFFE.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F000000×0x7F000000 → 0x7F800000, overflow=1.
  - 0x00800000×0x00800000 → 0x00000000, underflow=1.
- Backpressure: 6 back-to-back ops with tags 0–5, out_ready_i low for 5 cycles after the first output.
  - in_ready_o=0 throughout the stall.
  - All 6 results emerge in order, correct, with none lost or duplicated.
- Reset mid-flight: assert reset_ni=0 with 3 ops in the pipe → out_valid_o=0 immediately, no stale results after release. Repeat the 2.5×4 check with EXP_W=5, MAN_W=10 (0x4100×0x4400 → 0x4900).
